pkg_fft_output_axis_stall_detect: RTL and testbench

PKG_FFT_OUTPUT_AXIS_STALL_DETECT -- requirements
Module: pkg_fft_output_axis_stall_detect

---
 rtl/pkg_fft_output_mon_pkg.sv | 15 +
 rtl/pkg_fft_output_axis_stall_detect_if.sv | 12 +
 rtl/pkg_fft_output_sat_cnt.sv | 33 +++
 rtl/pkg_fft_output_axis_stall_detect.sv | 118 +++++++++++
 tb/tb_pkg_fft_output_axis_stall_detect.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pkg_fft_output_mon_pkg.sv
// Shared definitions for the pkg_fft_output stream monitors: FSM encoding
// and default sizing of the stall detector.
package pkg_fft_output_mon_pkg;

  localparam int DEF_STALL_THRESH = 16;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BLOCKED = 2'd3
  } mon_state_e;

endpackage

// File: rtl/pkg_fft_output_axis_stall_detect_if.sv
// AXI-Stream handshake pair of the pkg_fft_output result stream.
// The stall detector only taps it, so it uses the mon modport.
interface pkg_fft_output_axis_stall_detect_if;

  logic s_tvalid;
  logic s_tready;

  modport master (output s_tvalid, input  s_tready);
  modport slave  (input  s_tvalid, output s_tready);
  modport mon    (input  s_tvalid, input  s_tready);

endinterface

// File: rtl/pkg_fft_output_sat_cnt.sv
// Saturating up-counter with synchronous clear and load.
// Priority: clr over load over inc; holds at all-ones instead of wrapping.
module pkg_fft_output_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state takes the held value first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (load_i)                 cnt_d = load_val_i;
    else if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pkg_fft_output_axis_stall_detect.sv
// Observe-only stall detector on the pkg_fft_output result stream: flags
// runs of STALL_THRESH back-pressured cycles and keeps sticky statistics.
module pkg_fft_output_axis_stall_detect
  import pkg_fft_output_mon_pkg::*;
#(
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                                ap_clk,
  input  logic                                ap_rst_n,
  pkg_fft_output_axis_stall_detect_if.mon     s_axis,
  input  logic                                clear,
  output logic                                axis_block_sig,
  output logic                                stall_sticky,
  output logic                                protocol_err,
  output logic [CNT_W-1:0]                    stall_events,
  output logic [CNT_W-1:0]                    max_stall
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] max_stall_q, max_stall_d;
  logic             sticky_q, sticky_d;
  logic             perr_q, perr_d;

  logic hs, stall;
  logic run_load, run_inc, run_clr;
  logic enter_blk, end_run, perr_set;

  assign hs    = s_axis.s_tvalid &  s_axis.s_tready;
  assign stall = s_axis.s_tvalid & ~s_axis.s_tready;

  always_comb begin
    state_d   = state_q;
    run_load  = 1'b0;
    run_inc   = 1'b0;
    run_clr   = 1'b0;
    enter_blk = 1'b0;
    end_run   = 1'b0;
    perr_set  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_XFER: begin
        if (hs)         state_d = ST_XFER;
        else if (stall) begin
          state_d  = ST_WAIT;
          run_load = 1'b1;
        end else        state_d = ST_IDLE;
      end
      ST_WAIT, ST_BLOCKED: begin
        if (stall) begin
          run_inc = 1'b1;
          // run_q already counts the earlier stalls; this sample is the threshold one
          if (state_q == ST_WAIT && run_q >= THRESH_M1) begin
            state_d   = ST_BLOCKED;
            enter_blk = 1'b1;
          end
        end else begin
          end_run  = 1'b1;
          run_clr  = 1'b1;
          perr_set = ~hs;
          state_d  = hs ? ST_XFER : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // External clear takes precedence over any event landing in the same cycle.
  always_comb begin
    max_stall_d = max_stall_q;
    if (clear)                                max_stall_d = '0;
    else if (end_run && run_q > max_stall_q)  max_stall_d = run_q;
    sticky_d = clear ? 1'b0 : (sticky_q | enter_blk);
    perr_d   = clear ? 1'b0 : (perr_q   | perr_set);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      max_stall_q <= '0;
      sticky_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_stall_q <= max_stall_d;
      sticky_q    <= sticky_d;
      perr_q      <= perr_d;
    end
  end

  pkg_fft_output_sat_cnt #(.CNT_W(CNT_W)) u_run_cnt (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .clr_i      (run_clr),
    .load_i     (run_load),
    .inc_i      (run_inc),
    .load_val_i (CNT_W'(1)),
    .cnt_o      (run_q)
  );

  pkg_fft_output_sat_cnt #(.CNT_W(CNT_W)) u_evt_cnt (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .clr_i      (clear),
    .load_i     (1'b0),
    .inc_i      (enter_blk),
    .load_val_i ('0),
    .cnt_o      (stall_events)
  );

  assign axis_block_sig = (state_q == ST_BLOCKED);
  assign stall_sticky   = sticky_q;
  assign protocol_err   = perr_q;
  assign max_stall      = max_stall_q;

endmodule

// File: tb/tb_pkg_fft_output_axis_stall_detect.sv
// Directed bench for the stall detector: a table of stall-run scenarios
// plus hand-written sequences for reset, clear and accumulation corners.
module tb_pkg_fft_output_axis_stall_detect;

  localparam int TH = 16;
  localparam int CW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          clear;
  logic          axis_block_sig;
  logic          stall_sticky;
  logic          protocol_err;
  logic [CW-1:0] stall_events;
  logic [CW-1:0] max_stall;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  pkg_fft_output_axis_stall_detect_if s_axis ();

  pkg_fft_output_axis_stall_detect #(.STALL_THRESH(TH), .CNT_W(CW)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .s_axis         (s_axis),
    .clear          (clear),
    .axis_block_sig (axis_block_sig),
    .stall_sticky   (stall_sticky),
    .protocol_err   (protocol_err),
    .stall_events   (stall_events),
    .max_stall      (max_stall)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and return just after the sampling edge.
  task automatic cyc(input logic v, input logic r, input logic c);
    s_axis.s_tvalid = v;
    s_axis.s_tready = r;
    clear           = c;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input int ev, input int mx,
                             input int st, input int pe);
    check({tag, "_events"}, stall_events, ev);
    check({tag, "_max"},    max_stall,    mx);
    check({tag, "_sticky"}, stall_sticky, st);
    check({tag, "_perr"},   protocol_err, pe);
  endtask

  // Stall for n cycles; count cycles where the flag disagrees with the threshold rule.
  task automatic stall_run(input int n, output int errs);
    errs = 0;
    for (int k = 1; k <= n; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (axis_block_sig !== (k >= TH)) errs++;
    end
  endtask

  typedef struct {
    int len;
    bit end_hs;
    int exp_events;
    int exp_max;
    bit exp_sticky;
    bit exp_perr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int errs;
    int hi;

    tbl[0] = '{len: 15, end_hs: 1'b1, exp_events: 0, exp_max: 15, exp_sticky: 1'b0, exp_perr: 1'b0};
    tbl[1] = '{len: 40, end_hs: 1'b1, exp_events: 1, exp_max: 40, exp_sticky: 1'b1, exp_perr: 1'b0};
    tbl[2] = '{len: 20, end_hs: 1'b0, exp_events: 1, exp_max: 20, exp_sticky: 1'b1, exp_perr: 1'b1};
    tbl[3] = '{len: 16, end_hs: 1'b1, exp_events: 1, exp_max: 16, exp_sticky: 1'b1, exp_perr: 1'b0};
    tbl[4] = '{len:  1, end_hs: 1'b0, exp_events: 0, exp_max:  1, exp_sticky: 1'b0, exp_perr: 1'b1};
    tbl[5] = '{len:  2, end_hs: 1'b1, exp_events: 0, exp_max:  2, exp_sticky: 1'b0, exp_perr: 1'b0};
    tbl[6] = '{len: 17, end_hs: 1'b0, exp_events: 1, exp_max: 17, exp_sticky: 1'b1, exp_perr: 1'b1};

    s_axis.s_tvalid = 1'b0;
    s_axis.s_tready = 1'b0;
    clear           = 1'b0;
    ap_rst_n        = 1'b0;
    #1;
    check("rst_block", axis_block_sig, 0);
    check_stats("rst", 0, 0, 0, 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Continuous transfer never stalls.
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (axis_block_sig) hi++;
    end
    check("xfer_block_cycles", hi, 0);
    check_stats("xfer", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(1'b0, 1'b0, 1'b1);
      stall_run(tbl[i].len, errs);
      cyc(tbl[i].end_hs, tbl[i].end_hs, 1'b0);
      check($sformatf("row%0d_trace", i), errs, 0);
      check($sformatf("row%0d_blk_after", i), axis_block_sig, 0);
      check_stats($sformatf("row%0d", i), tbl[i].exp_events, tbl[i].exp_max,
                  tbl[i].exp_sticky, tbl[i].exp_perr);
    end

    // Clear after a protocol error zeroes every statistic.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check_stats("clr", 0, 0, 0, 0);

    // Statistics accumulate across runs; max keeps the longest.
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    stall_run(40, errs);
    cyc(1'b1, 1'b1, 1'b0);
    stall_run(10, errs);
    cyc(1'b1, 1'b1, 1'b0);
    check_stats("acc1", 1, 40, 1, 0);
    stall_run(17, errs);
    cyc(1'b0, 1'b0, 1'b0);
    check_stats("acc2", 2, 40, 1, 1);

    // Clear coincident with a max_stall update: clear wins.
    stall_run(50, errs);
    cyc(1'b1, 1'b1, 1'b1);
    check_stats("clr_upd", 0, 0, 0, 0);

    // Clear on the WAIT->BLOCKED sample discards the entry event only.
    stall_run(TH - 1, errs);
    cyc(1'b1, 1'b0, 1'b1);
    check("clr_blk_block", axis_block_sig, 1);
    check("clr_blk_events", stall_events, 0);
    check("clr_blk_sticky", stall_sticky, 0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check_stats("clr_blk_end", 0, 20, 0, 0);

    // Reset in the middle of a blocked run.
    cyc(1'b0, 1'b0, 1'b1);
    stall_run(24, errs);
    check("rst_mid_pre", axis_block_sig, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rst_mid_block", axis_block_sig, 0);
    check("rst_mid_events", stall_events, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    check_stats("rst_mid_post", 0, 0, 0, 0);
    stall_run(15, errs);
    cyc(1'b1, 1'b1, 1'b0);
    check("rst_fresh_trace", errs, 0);
    check_stats("rst_fresh", 0, 15, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
